// File: rtl/uart_tx_fifo.sv
// UART transmitter with configurable frame format and an internal transmit FIFO.
// Words are accepted on a valid/ready handshake and sent back-to-back, LSB first.
module uart_tx_fifo #(
  parameter int unsigned DIVISOR    = 10416,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        tx_port,
  output logic                        tx_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = $clog2(STOP_BITS * DIVISOR);
  localparam int unsigned BW = $clog2(DATA_BITS);
  localparam logic [LW-1:0] DEPTH_L     = LW'(FIFO_DEPTH);
  localparam logic [CW-1:0] BIT_RELOAD  = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] STOP_RELOAD = CW'(STOP_BITS * DIVISOR - 1);
  localparam logic [BW-1:0] LAST_BIT    = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [LW-1:0]        wr_ptr, rd_ptr, level, level_n;
  logic                 push, pop, empty;
  logic [DATA_BITS-1:0] head;
  logic                 head_par;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [BW-1:0]        bitno, bitno_n;
  logic                 par_bit, par_n;
  logic                 port_n;

  assign push       = tx_valid && tx_ready;
  assign level      = wr_ptr - rd_ptr;
  assign empty      = (level == '0);
  assign head       = mem[rd_ptr[AW-1:0]];
  assign head_par   = (^head) ^ (PARITY == 1);
  assign fifo_level = level;
  assign tx_busy    = (state != IDLE);

  always_comb begin
    level_n = level;
    if (push && !pop)      level_n = level + LW'(1);
    else if (!push && pop) level_n = level - LW'(1);
  end

  always_ff @(posedge sys_clk) begin
    if (push && !sys_rst) mem[wr_ptr[AW-1:0]] <= tx_data;
  end

  // tx_ready follows the post-edge level, so it never admits a push into a full FIFO
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_ready <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + LW'(1);
      if (pop)  rd_ptr <= rd_ptr + LW'(1);
      tx_ready <= (level_n != DEPTH_L);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      shift   <= '0;
      bitno   <= '0;
      par_bit <= 1'b0;
      tx_port <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      shift   <= shift_n;
      bitno   <= bitno_n;
      par_bit <= par_n;
      tx_port <= port_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    shift_n = shift;
    bitno_n = bitno;
    par_n   = par_bit;
    port_n  = tx_port;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        port_n = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_n = head;
          par_n   = head_par;
          port_n  = 1'b0;
          cnt_n   = BIT_RELOAD;
          state_n = START;
        end
      end
      START: begin
        if (cnt == '0) begin
          port_n  = shift[0];
          shift_n = shift >> 1;
          bitno_n = '0;
          cnt_n   = BIT_RELOAD;
          state_n = DATA;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      DATA: begin
        if (cnt == '0) begin
          cnt_n = BIT_RELOAD;
          if (bitno != LAST_BIT) begin
            port_n  = shift[0];
            shift_n = shift >> 1;
            bitno_n = bitno + BW'(1);
          end else if (PARITY != 0) begin
            port_n  = par_bit;
            state_n = PAR;
          end else begin
            port_n  = 1'b1;
            cnt_n   = STOP_RELOAD;
            state_n = STOP;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      PAR: begin
        if (cnt == '0) begin
          port_n  = 1'b1;
          cnt_n   = STOP_RELOAD;
          state_n = STOP;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      STOP: begin
        // all stop bits share one counter run of STOP_BITS*DIVISOR cycles
        if (cnt == '0) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_n = head;
            par_n   = head_par;
            port_n  = 1'b0;
            cnt_n   = BIT_RELOAD;
            state_n = START;
          end else begin
            port_n  = 1'b1;
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: begin
        port_n  = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: four frame formats, each serial line decoded
// cycle by cycle against a waveform built from the accepted words.
module tb_uart_tx_fifo;

  localparam int DIVS [4]  = '{16, 4, 4, 4};
  localparam int NBITS [4] = '{8, 7, 8, 8};
  localparam int PARS [4]  = '{0, 2, 1, 0};
  localparam int STOPS [4] = '{1, 2, 1, 1};

  logic            sys_clk = 1'b0;
  logic            sys_rst = 1'b1;
  logic [3:0]      valid_w = '0;
  logic [3:0]      ready_w, port_w, busy_w;
  logic [3:0][7:0] data_w  = '0;
  logic [3:0][2:0] lvl_w;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int sbq[$];
  int last_acc [4] = '{default: 0};
  int starts [4][16];
  int nfr [4] = '{default: 0};

  always #5 sys_clk = ~sys_clk;

  uart_tx_fifo #(.DIVISOR(16), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_data(data_w[0]), .tx_valid(valid_w[0]),
    .tx_ready(ready_w[0]), .tx_port(port_w[0]), .tx_busy(busy_w[0]), .fifo_level(lvl_w[0]));
  uart_tx_fifo #(.DIVISOR(4), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(4)) dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_data(data_w[1][6:0]), .tx_valid(valid_w[1]),
    .tx_ready(ready_w[1]), .tx_port(port_w[1]), .tx_busy(busy_w[1]), .fifo_level(lvl_w[1]));
  uart_tx_fifo #(.DIVISOR(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_data(data_w[2]), .tx_valid(valid_w[2]),
    .tx_ready(ready_w[2]), .tx_port(port_w[2]), .tx_busy(busy_w[2]), .fifo_level(lvl_w[2]));
  uart_tx_fifo #(.DIVISOR(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) dut3 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_data(data_w[3]), .tx_valid(valid_w[3]),
    .tx_ready(ready_w[3]), .tx_port(port_w[3]), .tx_busy(busy_w[3]), .fifo_level(lvl_w[3]));

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] mask(input int i);
    return 8'hFF >> (8 - NBITS[i]);
  endfunction

  function automatic logic [15:0] frame_bits(input int i, input logic [7:0] w);
    logic [15:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int k = 0; k < NBITS[i]; k++) f[1 + k] = w[k];
    if (PARS[i] != 0) f[1 + NBITS[i]] = (^w) ^ (PARS[i] == 1);
    return f;
  endfunction

  function automatic int sb_find(input int i);
    for (int k = 0; k < sbq.size(); k++)
      if ((sbq[k] >> 8) == i) return k;
    return -1;
  endfunction

  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 4; i++)
      if (!sys_rst && valid_w[i] && ready_w[i]) begin
        sbq.push_back(i * 256 + int'(data_w[i] & mask(i)));
        last_acc[i] <= cyc + 1;
      end
  end

  task automatic monitor(input int i);
    int idx, ent, nb, mism, b;
    logic [7:0] w, obs;
    logic [15:0] expf;
    bit abort;
    forever begin
      @(negedge sys_clk);
      if (sys_rst || port_w[i] !== 1'b0) continue;
      if (nfr[i] < 16) starts[i][nfr[i]] = cyc;
      nfr[i]++;
      idx = sb_find(i);
      check($sformatf("frame_expected%0d", i), (idx >= 0) ? 1 : 0, 1);
      w = '0;
      if (idx >= 0) begin
        ent = sbq[idx];
        w = ent[7:0];
      end
      expf = frame_bits(i, w);
      nb = 1 + NBITS[i] + ((PARS[i] != 0) ? 1 : 0) + STOPS[i];
      mism = 0;
      obs = '0;
      abort = 0;
      for (int c = 0; c < nb * DIVS[i]; c++) begin
        if (c > 0) @(negedge sys_clk);
        if (sys_rst) begin
          abort = 1;
          break;
        end
        b = c / DIVS[i];
        if (port_w[i] !== expf[b]) mism++;
        if (busy_w[i] !== 1'b1) mism++;
        if ((c % DIVS[i]) == DIVS[i] / 2 && b >= 1 && b <= NBITS[i]) obs[b - 1] = port_w[i];
      end
      if (!abort) begin
        check($sformatf("frame_line%0d", i), mism, 0);
        check($sformatf("frame_data%0d", i), int'(obs), int'(w));
        idx = sb_find(i);
        if (idx >= 0) sbq.delete(idx);
      end
    end
  endtask

  task automatic send(input int i, input logic [7:0] d);
    logic r;
    int t;
    @(posedge sys_clk);
    #1;
    data_w[i] = d;
    valid_w[i] = 1'b1;
    r = 1'b0;
    t = 0;
    while (!r && t < 200) begin
      @(negedge sys_clk);
      r = ready_w[i];
      @(posedge sys_clk);
      #1;
      t++;
    end
    valid_w[i] = 1'b0;
    check($sformatf("accept%0d", i), int'(r), 1);
  endtask

  task automatic busy_len(input int i, output int n);
    int t;
    t = 0;
    n = 0;
    @(negedge sys_clk);
    while (!busy_w[i] && t < 20) begin
      @(negedge sys_clk);
      t++;
    end
    while (busy_w[i] && n < 4000) begin
      n++;
      @(negedge sys_clk);
    end
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
      monitor(2);
      monitor(3);
    join_none
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, b, k, t, maxlv, viol, removed;
    logic r;
    logic [7:0] words [6];
    int acc [6];

    repeat (3) @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_port%0d", i), int'(port_w[i]), 1);
      check($sformatf("rst_ready%0d", i), int'(ready_w[i]), 1);
      check($sformatf("rst_busy%0d", i), int'(busy_w[i]), 0);
      check($sformatf("rst_level%0d", i), int'(lvl_w[i]), 0);
    end

    // 8N1, DIVISOR 16: latency and busy length
    send(0, 8'h55);
    check("lat_level0", int'(lvl_w[0]), 1);
    check("lat_port_idle0", int'(port_w[0]), 1);
    check("lat_busy_idle0", int'(busy_w[0]), 0);
    @(posedge sys_clk);
    #1;
    check("lat_port_start0", int'(port_w[0]), 0);
    check("lat_busy_start0", int'(busy_w[0]), 1);
    busy_len(0, n);
    check("busy_len0", n, 160);
    check("frames0", nfr[0], 1);
    check("start_lat0", starts[0][0] - last_acc[0], 1);

    // 7E2, DIVISOR 4
    send(1, 8'h23);
    busy_len(1, n);
    check("busy_len1", n, 44);
    check("frames1", nfr[1], 1);

    // 8O1, DIVISOR 4: two back-to-back frames
    send(2, 8'hFF);
    send(2, 8'h01);
    busy_len(2, n);
    check("frames2", nfr[2], 2);
    check("spacing2", starts[2][1] - starts[2][0], 44);

    // FIFO fill with tx_valid held high
    words = '{8'hA1, 8'h5E, 8'h00, 8'hFF, 8'h3C, 8'h96};
    b = nfr[3];
    k = 0;
    t = 0;
    maxlv = 0;
    viol = 0;
    @(posedge sys_clk);
    #1;
    data_w[3] = words[0];
    valid_w[3] = 1'b1;
    while (k < 6 && t < 1000) begin
      @(negedge sys_clk);
      r = ready_w[3];
      if (int'(lvl_w[3]) > maxlv) maxlv = int'(lvl_w[3]);
      if (lvl_w[3] == 3'd4 && ready_w[3]) viol++;
      @(posedge sys_clk);
      #1;
      t++;
      if (r) begin
        acc[k] = cyc;
        k++;
        if (k < 6) data_w[3] = words[k];
      end
    end
    valid_w[3] = 1'b0;
    check("fifo_accepted", k, 6);
    check("fifo_max_level", maxlv, 4);
    check("fifo_ready_full", viol, 0);
    check("fifo_burst", acc[4] - acc[0], 4);
    check("fifo_refill", acc[5] - acc[0], 42);
    busy_len(3, n);
    check("fifo_busy_tail", n, 199);
    check("fifo_frames", nfr[3] - b, 6);
    for (int j = 0; j < 5; j++)
      check($sformatf("fifo_spacing%0d", j), starts[3][b + j + 1] - starts[3][b + j], 40);

    // reset mid-frame with two words queued, push attempted on the reset edge
    send(3, 8'h11);
    send(3, 8'h22);
    send(3, 8'h33);
    check("pre_rst_level", int'(lvl_w[3]), 2);
    repeat (10) @(posedge sys_clk);
    #1;
    sys_rst = 1'b1;
    data_w[3] = 8'h77;
    valid_w[3] = 1'b1;
    @(posedge sys_clk);
    #1;
    sys_rst = 1'b0;
    valid_w[3] = 1'b0;
    check("mid_rst_port", int'(port_w[3]), 1);
    check("mid_rst_busy", int'(busy_w[3]), 0);
    check("mid_rst_level", int'(lvl_w[3]), 0);
    check("mid_rst_ready", int'(ready_w[3]), 1);
    removed = 0;
    while (sb_find(3) >= 0) begin
      sbq.delete(sb_find(3));
      removed++;
    end
    check("mid_rst_discarded", removed, 3);
    b = nfr[3];
    viol = 0;
    repeat (60) begin
      @(negedge sys_clk);
      if (port_w[3] !== 1'b1) viol++;
    end
    check("post_rst_line_idle", viol, 0);
    check("post_rst_no_frame", nfr[3] - b, 0);

    // push on the edge where the last stop bit expires with an empty FIFO
    b = nfr[3];
    send(3, 8'hC3);
    t = last_acc[3];
    repeat (40) @(posedge sys_clk);
    #1;
    data_w[3] = 8'h3C;
    valid_w[3] = 1'b1;
    @(posedge sys_clk);
    #1;
    valid_w[3] = 1'b0;
    check("late_push_time", last_acc[3] - t, 41);
    check("late_idle_busy", int'(busy_w[3]), 0);
    check("late_idle_port", int'(port_w[3]), 1);
    @(posedge sys_clk);
    #1;
    check("late_start_port", int'(port_w[3]), 0);
    check("late_start_busy", int'(busy_w[3]), 1);
    busy_len(3, n);
    check("late_frames", nfr[3] - b, 2);
    check("late_spacing", starts[3][b + 1] - starts[3][b], 41);

    repeat (5) @(posedge sys_clk);
    check("sb_empty", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
